key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels (>=1).
REQ-002 SHALL have parameter TICK_DIV, default 100000: clk cycles per sample tick (>=2).
REQ-003 SHALL have parameter STABLE_CNT, default 20: consecutive differing ticks required to accept a new level (>=1).
REQ-004 SHALL have parameter HOLD_TICKS, default 1000: ticks at level 1 before a long-press is flagged (>=1; used only with KEY_DEBOUNCE_HOLD_EN).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port inp, input, N_CH bits: raw asynchronous key/switch levels.
REQ-008 SHALL have port outp, output, N_CH bits: debounced level per channel, registered.
REQ-009 SHALL have port rise, output, N_CH bits: one-clk pulse when outp[i] goes 0->1.
REQ-010 SHALL have port fall, output, N_CH bits: one-clk pulse when outp[i] goes 1->0.
REQ-011 SHALL have port hold, output, N_CH bits, present only with KEY_DEBOUNCE_HOLD_EN: long-press flag.

Function
REQ-012 SHALL pass each inp[i] through a 2-flop synchronizer; only the second stage (s[i]) is used downstream.
REQ-013 SHALL use one shared tick counter, width $clog2(TICK_DIV), counting 0..TICK_DIV-1 and wrapping to 0; tick is high for exactly the one clk where the count equals TICK_DIV-1.
REQ-014 SHALL keep a per-channel stability counter c[i], width $clog2(STABLE_CNT+1), updated only on tick cycles.
REQ-015 On tick, if s[i]==outp[i], SHALL clear c[i] to 0, so any single agreeing sample restarts qualification.
REQ-016 On tick, if s[i]!=outp[i] and c[i]<STABLE_CNT-1, SHALL increment c[i].
REQ-017 On tick, if s[i]!=outp[i] and c[i]==STABLE_CNT-1, SHALL set outp[i]<=s[i] and clear c[i] in the same cycle.
REQ-018 SHALL assert rise[i] or fall[i] in the clk cycle after outp[i] changes, for exactly one clk; rise and fall SHALL never be high together on one channel.
REQ-019 SHALL never let c[i] exceed STABLE_CNT-1; no counter wraps.
REQ-020 Latency: acceptance SHALL occur on the STABLE_CNT-th consecutive differing tick, i.e. between (STABLE_CNT-1)*TICK_DIV+2 and STABLE_CNT*TICK_DIV+2 clks after a stable inp change.
REQ-021 SHALL process channels fully independently; simultaneous changes on several channels SHALL all be accepted on the same tick.
REQ-022 A pulse on inp[i] shorter than (STABLE_CNT-1)*TICK_DIV clks SHALL never change outp[i].

Reset
REQ-023 While rst=1 at a clk edge, SHALL clear the tick counter, both synchronizer stages, c[], outp, rise, fall and hold (and hold counters) to 0.
REQ-024 SHALL abandon any qualification in progress on mid-operation reset; after rst deasserts, tick counting restarts from 0.
REQ-025 A channel whose inp is 1 through reset SHALL be treated as a new change after reset and qualify per REQ-020.

Configuration
REQ-026 With macro KEY_DEBOUNCE_HOLD_EN defined, SHALL add the hold port and a per-channel counter, width $clog2(HOLD_TICKS+1), that clears whenever outp[i]==0 and increments on each tick while outp[i]==1, saturating at HOLD_TICKS.
REQ-027 With KEY_DEBOUNCE_HOLD_EN defined, SHALL drive hold[i]=1 exactly while its counter equals HOLD_TICKS; hold[i] SHALL drop in the cycle after outp[i] falls.
REQ-028 Without KEY_DEBOUNCE_HOLD_EN, SHALL omit the hold port and its logic; all other behaviour SHALL be identical.

Verification (N_CH=2, TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=5 unless noted)
REQ-029 SHALL cover: reset with inp=2'b00 -> outp, rise and fall stay 0 indefinitely.
REQ-030 SHALL cover: inp[0] 0->1 held steady -> outp[0]=1 within 10..14 clks, rise[0] a single one-clk pulse, outp[1] unchanged.
REQ-031 SHALL cover: inp[1] high for 5 clks then low -> outp[1], rise[1] and fall[1] remain 0.
REQ-032 SHALL cover: inp=2'b11 applied together -> both outp bits set in the same cycle; later inp[0]->0 -> one fall[0] pulse only.
REQ-033 SHALL cover: rst asserted one tick before acceptance -> outp=0, and re-qualification takes the full 10..14 clks after release.
REQ-034 SHALL cover: with KEY_DEBOUNCE_HOLD_EN, outp[0]=1 for 5 ticks -> hold[0]=1; inp[0] released -> hold[0]=0 the cycle after outp[0] falls.

Source files
------------

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: 2-flop sync, shared sample tick, per-channel stability counters.
// Optional long-press flag when KEY_DEBOUNCE_HOLD_EN is defined (adds the hold port).
module key_debounce #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 20,
    parameter int HOLD_TICKS = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] inp,
    output logic [N_CH-1:0] outp,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
`ifdef KEY_DEBOUNCE_HOLD_EN
    ,
    output logic [N_CH-1:0] hold
`endif
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_LAST    = CW'(STABLE_CNT - 1);

    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [N_CH-1:0] sync_p0;
    logic [N_CH-1:0] sync_p1;
    logic [N_CH-1:0] outp_prev;
    logic [CW-1:0]   stab_cnt [N_CH];

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Edge pulses are derived from the registered level, so they lag outp by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            outp      <= '0;
            outp_prev <= '0;
            rise      <= '0;
            fall      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            sync_p0   <= inp;
            sync_p1   <= sync_p0;
            outp_prev <= outp;
            rise      <= outp & ~outp_prev;
            fall      <= ~outp & outp_prev;
            if (tick) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (sync_p1[i] == outp[i]) begin
                        stab_cnt[i] <= '0;
                    end else if (stab_cnt[i] == C_LAST) begin
                        outp[i]     <= sync_p1[i];
                        stab_cnt[i] <= '0;
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef KEY_DEBOUNCE_HOLD_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    logic [HW-1:0] hold_cnt [N_CH];

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_MAX) ? v : v + HW'(1);
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst || !outp[i]) begin
                hold_cnt[i] <= '0;
            end else if (tick) begin
                hold_cnt[i] <= sat_inc(hold_cnt[i]);
            end
        end
    end

    always_comb begin
        hold = '0;
        for (int i = 0; i < N_CH; i++) begin
            hold[i] = (hold_cnt[i] == HOLD_MAX);
        end
    end
`else
    // Default build carries no long-press tracking.
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected edge pulses are queued as stimulus is driven
// and popped by a monitor when rise/fall fire; level latencies are checked in each task.
module tb_key_debounce;

    localparam int N_CH       = 2;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;
    localparam int HOLD_TICKS = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] inp;
    logic [1:0] outp;
    logic [1:0] rise;
    logic [1:0] fall;
`ifdef KEY_DEBOUNCE_HOLD_EN
    logic [1:0] hold;
`endif

    key_debounce #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inp(inp),
        .outp(outp),
        .rise(rise),
        .fall(fall)
`ifdef KEY_DEBOUNCE_HOLD_EN
        ,
        .hold(hold)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] f;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_ev;
    int  checks = 0;
    int  errors = 0;

    task automatic push_ev(input logic [1:0] r, input logic [1:0] f);
        ev_t e;
        e.r = r;
        e.f = f;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every non-idle pulse cycle must match the next queued event.
    always @(negedge clk) begin
        if (!rst && ((rise | fall) != 2'b00)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse rise=%b fall=%b expected no pulse", rise, fall);
            end else begin
                got_ev = exp_q.pop_front();
                if ({rise, fall} !== {got_ev.r, got_ev.f}) begin
                    errors++;
                    $display("FAIL pulse_match rise=%b fall=%b expected rise=%b fall=%b",
                             rise, fall, got_ev.r, got_ev.f);
                end
            end
        end
    end

    // Counts posedges until (outp & m) == v; n = -1 when the budget expires.
    task automatic wait_outp(input logic [1:0] m, input logic [1:0] v, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if ((outp & m) == v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic bad;
        rst = 1'b1;
        inp = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({outp, rise, fall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state outp=%b rise=%b fall=%b expected all 0", outp, rise, fall);
        end
`ifdef KEY_DEBOUNCE_HOLD_EN
        checks++;
        if (hold !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold hold=%b expected 00", hold);
        end
`endif
        rst = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if ({outp, rise, fall} !== 6'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_after_reset outp=%b expected outputs to stay 0", outp);
        end
    endtask

    task automatic test_single_rise;
        int n;
        @(negedge clk);
        inp[0] = 1'b1;
        push_ev(2'b01, 2'b00);
        wait_outp(2'b01, 2'b01, 40, n);
        checks++;
        if (n < 10 || n > 14) begin
            errors++;
            $display("FAIL rise_latency got %0d clks expected 10..14", n);
        end
        checks++;
        if (outp[1] !== 1'b0) begin
            errors++;
            $display("FAIL rise_other_ch outp[1]=%b expected 0", outp[1]);
        end
        repeat (4) @(negedge clk);
        inp[0] = 1'b0;
        push_ev(2'b00, 2'b01);
        wait_outp(2'b01, 2'b00, 40, n);
        checks++;
        if (n < 10 || n > 14) begin
            errors++;
            $display("FAIL fall_latency got %0d clks expected 10..14", n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch;
        logic bad;
        @(negedge clk);
        inp[1] = 1'b1;
        repeat (5) @(negedge clk);
        inp[1] = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (outp[1] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL glitch_rejected outp[1] went to 1 expected 0");
        end
    endtask

    task automatic test_simultaneous;
        int  n;
        @(negedge clk);
        inp = 2'b11;
        push_ev(2'b11, 2'b00);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (outp != 2'b00) begin
                n = i;
                break;
            end
        end
        checks++;
        if (outp !== 2'b11 || n < 10 || n > 14) begin
            errors++;
            $display("FAIL both_accept outp=%b after %0d clks expected 11 within 10..14", outp, n);
        end
        repeat (4) @(negedge clk);
        inp = 2'b10;
        push_ev(2'b00, 2'b01);
        wait_outp(2'b01, 2'b00, 40, n);
        checks++;
        if (outp !== 2'b10 || n < 10 || n > 14) begin
            errors++;
            $display("FAIL partial_fall outp=%b after %0d clks expected 10 within 10..14", outp, n);
        end
        repeat (4) @(negedge clk);
        inp = 2'b00;
        push_ev(2'b00, 2'b10);
        wait_outp(2'b10, 2'b00, 40, n);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midqual;
        int n;
        @(negedge clk);
        rst = 1'b1;
        inp = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (outp !== 2'b00) begin
            errors++;
            $display("FAIL pre_reset_outp outp=%b expected 00 before acceptance", outp);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outp !== 2'b00) begin
            errors++;
            $display("FAIL midqual_reset outp=%b expected 00", outp);
        end
        @(negedge clk);
        rst = 1'b0;
        push_ev(2'b01, 2'b00);
        wait_outp(2'b01, 2'b01, 40, n);
        checks++;
        if (n < 10 || n > 14) begin
            errors++;
            $display("FAIL requalify_latency got %0d clks expected 10..14", n);
        end
        repeat (4) @(negedge clk);
        inp = 2'b00;
        push_ev(2'b00, 2'b01);
        wait_outp(2'b01, 2'b00, 40, n);
        repeat (4) @(negedge clk);
    endtask

`ifdef KEY_DEBOUNCE_HOLD_EN
    task automatic test_hold;
        int n;
        @(negedge clk);
        inp[0] = 1'b1;
        push_ev(2'b01, 2'b00);
        wait_outp(2'b01, 2'b01, 40, n);
        checks++;
        if (n < 0 || hold[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_early hold[0]=%b n=%0d expected 0 at acceptance", hold[0], n);
        end
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (hold[0] === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != HOLD_TICKS * TICK_DIV) begin
            errors++;
            $display("FAIL hold_latency got %0d clks expected %0d", n, HOLD_TICKS * TICK_DIV);
        end
        inp[0] = 1'b0;
        push_ev(2'b00, 2'b01);
        wait_outp(2'b01, 2'b00, 40, n);
        checks++;
        if (n < 0 || hold[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_at_fall hold[0]=%b n=%0d expected 1", hold[0], n);
        end
        @(negedge clk);
        checks++;
        if (hold[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_drop hold[0]=%b expected 0", hold[0]);
        end
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        inp = 2'b00;
        test_reset();
        test_single_rise();
        test_glitch();
        test_simultaneous();
        test_reset_midqual();
`ifdef KEY_DEBOUNCE_HOLD_EN
        test_hold();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses got %0d unmatched expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
